// File: rtl/hamming_pkg.sv
// Shared layout constants, widths and helpers for the (16,11) extended-Hamming code.
package hamming_pkg;

   localparam int DATA_W = 11;
   localparam int CODE_W = 16;
   localparam int SYN_W  = 4;
   localparam int PZ_IDX = 0;

   // Hamming positions carrying data bits d0..d10, and the check bits p0..p3
   localparam int DATA_IDX [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
   localparam int PARITY_IDX [SYN_W] = '{1, 2, 4, 8};

   typedef enum logic [1:0] {CLEAN, SINGLE, DOUBLE} err_class_e;

   // Pull the 11 data bits out of a codeword, d0 in the LSB
   function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W; i++) begin
         d[i] = code[DATA_IDX[i]];
      end
      return d;
   endfunction

   // Syndrome plus overall parity decide the error class; a pz-only error is single
   function automatic err_class_e classify(input logic [SYN_W-1:0] syn, input logic par);
      err_class_e c;
      if (par) begin
         c = SINGLE;
      end else if (syn != '0) begin
         c = DOUBLE;
      end else begin
         c = CLEAN;
      end
      return c;
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a 16-bit codeword.
module hamming_syndrome
   import hamming_pkg::*;
(
   input  logic [CODE_W-1:0] code_in,
   output logic [SYN_W-1:0]  syndrome,
   output logic              parity
);

   // Syndrome bit k is the XOR of every position whose index has bit k set
   always_comb begin
      syndrome = '0;
      for (int k = 0; k < SYN_W; k++) begin
         syndrome[k] = code_in[PARITY_IDX[k]];
         for (int i = 0; i < DATA_W; i++) begin
            if (((DATA_IDX[i] >> k) & 1) != 0) begin
               syndrome[k] = syndrome[k] ^ code_in[DATA_IDX[i]];
            end
         end
      end
      parity = code_in[PZ_IDX] ^ (^code_in[CODE_W-1:1]);
   end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control and saturating error counters.
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CODE_W-1:0] code_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              err_single,
   output logic              err_double,
   output logic [SYN_W-1:0]  err_pos,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_count,
   output logic [CNT_W-1:0]  uncorr_count
);

   logic              s1_valid_q, s1_valid_d;
   logic [CODE_W-1:0] s1_code_q, s1_code_d;
   logic [SYN_W-1:0]  s1_syn_q, s1_syn_d;
   logic              s1_par_q, s1_par_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_single_q, err_single_d;
   logic              err_double_q, err_double_d;
   logic [SYN_W-1:0]  err_pos_q, err_pos_d;
   logic [CNT_W-1:0]  corr_count_q, corr_count_d;
   logic [CNT_W-1:0]  uncorr_count_q, uncorr_count_d;

   logic [SYN_W-1:0]  syn_w;
   logic              par_w;
   logic [CODE_W-1:0] fixed_code;
   err_class_e        err_class;
   logic              s1_adv, s2_adv, out_fire;

   hamming_syndrome u_syndrome (
      .code_in  (code_in),
      .syndrome (syn_w),
      .parity   (par_w)
   );

   // Classify the stage-1 word and flip the bit the syndrome points at
   always_comb begin
      err_class  = classify(s1_syn_q, s1_par_q);
      fixed_code = s1_code_q;
      if (err_class == SINGLE && s1_syn_q != '0) begin
         fixed_code[s1_syn_q] = ~s1_code_q[s1_syn_q];
      end
   end

   // Pipeline advance, next-state for both stages and the saturating counters
   always_comb begin
      s2_adv   = !s2_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      out_fire = s2_valid_q && out_ready;

      s1_valid_d     = s1_valid_q;
      s1_code_d      = s1_code_q;
      s1_syn_d       = s1_syn_q;
      s1_par_d       = s1_par_q;
      s2_valid_d     = s2_valid_q;
      data_d         = data_q;
      err_single_d   = err_single_q;
      err_double_d   = err_double_q;
      err_pos_d      = err_pos_q;
      corr_count_d   = corr_count_q;
      uncorr_count_d = uncorr_count_q;

      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_code_d = code_in;
            s1_syn_d  = syn_w;
            s1_par_d  = par_w;
         end
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            data_d       = extract_data(fixed_code);
            err_single_d = (err_class == SINGLE);
            err_double_d = (err_class == DOUBLE);
            err_pos_d    = (err_class == SINGLE) ? s1_syn_q : '0;
         end
      end

      if (cnt_clr) begin
         corr_count_d   = '0;
         uncorr_count_d = '0;
      end else if (out_fire) begin
         if (err_single_q && corr_count_q != {CNT_W{1'b1}}) begin
            corr_count_d = corr_count_q + CNT_W'(1);
         end
         if (err_double_q && uncorr_count_q != {CNT_W{1'b1}}) begin
            uncorr_count_d = uncorr_count_q + CNT_W'(1);
         end
      end
   end

   // State registers; reset drops any in-flight words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q     <= 1'b0;
         s1_code_q      <= '0;
         s1_syn_q       <= '0;
         s1_par_q       <= 1'b0;
         s2_valid_q     <= 1'b0;
         data_q         <= '0;
         err_single_q   <= 1'b0;
         err_double_q   <= 1'b0;
         err_pos_q      <= '0;
         corr_count_q   <= '0;
         uncorr_count_q <= '0;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_code_q      <= s1_code_d;
         s1_syn_q       <= s1_syn_d;
         s1_par_q       <= s1_par_d;
         s2_valid_q     <= s2_valid_d;
         data_q         <= data_d;
         err_single_q   <= err_single_d;
         err_double_q   <= err_double_d;
         err_pos_q      <= err_pos_d;
         corr_count_q   <= corr_count_d;
         uncorr_count_q <= uncorr_count_d;
      end
   end

   assign in_ready     = s1_adv;
   assign out_valid    = s2_valid_q;
   assign data_out     = data_q;
   assign err_single   = err_single_q;
   assign err_double   = err_double_q;
   assign err_pos      = err_pos_q;
   assign corr_count   = corr_count_q;
   assign uncorr_count = uncorr_count_q;

endmodule
